axil_mem_arbiter: RTL and testbench
===================================

# axil_mem_arbiter

Two-to-one AXI-Lite arbiter that lets two cache-side managers share one memory port. Typical placement: instruction-cache `mem` port on `req0`, data-cache `mem` port on `req1`, and the `mem` port driving `AxilMemory.port_rw`. The arbiter carries one transaction at a time, read or write, and chooses between the two requesters by round-robin. Requests are registered toward memory, and responses pass combinationally back to the granted requester.

## Interface
- `ADDR_WIDTH`, default 32: address width of all ports.
- `DATA_WIDTH`, default 32: data width of all ports. `WSTRB` is `DATA_WIDTH/8` bits.
- `ACLK`  in  1  clock; all state updates on its rising edge.
- `ARESET`  in  1  reset; asynchronous, active-high.
- `req0`  `axi_if.subord`  interface  requester 0. Wins the first arbitration after reset.
- `req1`  `axi_if.subord`  interface  requester 1.
- `mem`  `axi_if.manager`  interface  shared downstream memory port.

## Operation
- **Pending request.**
  - Requester *i* has a pending read when `ARVALID` is 1.
  - It has a pending write when `AWVALID` and `WVALID` are both 1.
  - If one requester has both pending at once, the read wins.
- **States:** `ARB_IDLE`, `ARB_RD_ADDR`, `ARB_RD_DATA`, `ARB_WR_REQ`, `ARB_WR_RESP`.
- **`ARB_IDLE`.** Pick the winner, accept its request combinationally and latch it.
  - With one requester pending, it wins. With both pending, the winner is the requester other than `last_grant`.
  - Read: assert the winner's `ARREADY`. Latch `ARADDR`, set `grant`, set `last_grant`, go to `ARB_RD_ADDR`.
  - Write: assert the winner's `AWREADY` and `WREADY` together. Latch `AWADDR`, `WDATA`, `WSTRB`, go to `ARB_WR_REQ`.
- **`ARB_RD_ADDR`.** Drive `mem.ARVALID`=1 with the latched address. On `mem.ARREADY`, go to `ARB_RD_DATA`.
- **`ARB_RD_DATA`.**
  - `req[grant].RVALID`=`mem.RVALID`; `RDATA` and `RRESP` pass through.
  - `mem.RREADY`=`req[grant].RREADY`.
  - On the R handshake, go to `ARB_IDLE`.
- **`ARB_WR_REQ`.**
  - Drive `mem.AWVALID` and `mem.WVALID`. Each drops independently after its own handshake; track this with flags `aw_done` and `w_done`.
  - When both handshakes are complete (either the same cycle or different cycles), go to `ARB_WR_RESP`.
- **`ARB_WR_RESP`.** Pass `BVALID`/`BRESP` to the granted requester and `BREADY` back to memory. On the B handshake, go to `ARB_IDLE`.
- **Non-granted requester, and both requesters outside `ARB_IDLE` acceptance:** all READY and VALID outputs are 0; `RDATA` and `RRESP` are 0.
- **Memory side:** `mem.ARPROT` and `mem.AWPROT` are constant 0. Response codes are forwarded unmodified.

## Timing
- **Reset values** (asynchronous, while `ARESET`=1):
  - state `ARB_IDLE`, `last_grant`=1, `grant`=0, `aw_done`=`w_done`=0.
  - All `mem` VALID and READY outputs 0; `mem.ARADDR`, `AWADDR`, `WDATA`, `WSTRB` are 0.
  - All requester READY and VALID outputs 0.
- **Reset mid-transaction:** the transaction is abandoned with no response to the requester. Outputs return to their reset values immediately, not at the next clock edge.
- **Acceptance:** in `ARB_IDLE` a request is accepted in the same cycle its VALID is seen. READY depends on VALID; VALID never depends on READY.
- **Read latency against `AxilMemory`:**
  - cycle 0: accept.
  - cycle 1: `mem.ARVALID`, accepted by memory.
  - cycle 2: `mem.RVALID`, forwarded; requester RREADY=1.
  - cycle 3: back in `ARB_IDLE`, next accept possible.
  - Throughput: one transaction per 3 cycles.
- **Write latency:** same shape as a read; B is forwarded at cycle 2.
- **Stability:** latched address and data hold constant while the corresponding `mem` VALID is high.
- **Responses:** no response reaches a requester that does not hold the grant.

## Structure
- Package `axil_arb_pkg` holds:
  - the enum `arb_state_t`;
  - a localparam for the idle grant reset value;
  - `RESP_OK`, shared with existing blocks via the package instead of a macro.
- No sub-module is needed. Grant selection is a few lines of combinational logic inside the block.

## Test plan
- **Single read:** `req0` reads 0x0000_0010, memory holds 0xDEAD_BEEF.
  - `req0` gets RVALID with RDATA=0xDEAD_BEEF at cycle 2.
  - `req1` outputs stay 0 throughout.
- **Simultaneous reads** to 0x4 (`req0`) and 0x8 (`req1`) at cycle 0:
  - `req0` is served first.
  - `req1` is accepted at cycle 3 and gets its data at cycle 5.
  - A repeat of both requests then serves `req0` before `req1` again (alternation).
- **Write then read:** `req1` writes 0x1234_5678 to 0x20 with WSTRB=0xF.
  - BVALID arrives at cycle 2.
  - `req0` then reads 0x20 and gets 0x1234_5678.
- **Back-pressure:** `req0` holds RREADY=0 for 4 cycles after `mem.RVALID`.
  - `mem.RREADY` stays 0 and RDATA stays stable.
  - The grant is held and `req1` (pending) is not accepted until the R handshake completes.
- **Split write handshake:** memory gives AWREADY at cycle 1 and WREADY at cycle 3.
  - `mem.AWVALID` drops after cycle 1.
  - `mem.WVALID` stays high through cycle 3.
  - The state reaches `ARB_WR_RESP` at cycle 4.
- **Reset in `ARB_RD_DATA`:** `ARESET` pulses for 1 cycle.
  - All outputs go to 0 asynchronously; state is `ARB_IDLE`.
  - A following `req1` read is granted first (`last_grant`=1 rule gives `req0` priority only on a tie).

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-to-one AXI-Lite memory arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_RD_ADDR,
    ARB_RD_DATA,
    ARB_WR_REQ,
    ARB_WR_RESP
  } arb_state_t;

  // last_grant starts at 1 so that requester 0 wins the first tie after reset
  localparam logic IDLE_LAST_GRANT = 1'b1;

  localparam logic [1:0] RESP_OK = 2'b00;

endpackage

// File: rtl/axi_if.sv
// AXI-Lite bundle with manager and subordinate views.
interface axi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport manager (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport subord (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axil_mem_arbiter.sv
// Round-robin two-to-one AXI-Lite arbiter, one transaction in flight at a time.
// Requests are registered toward memory; responses return combinationally.
//
// state       | meaning
// ARB_IDLE    | pick a winner, accept its AR or AW+W and latch it
// ARB_RD_ADDR | present latched read address to memory
// ARB_RD_DATA | forward R channel between memory and granted requester
// ARB_WR_REQ  | present latched AW and W, each dropping after its handshake
// ARB_WR_RESP | forward B channel between memory and granted requester
module axil_mem_arbiter
  import axil_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic    ACLK,
  input logic    ARESET,
  axi_if.subord  req0,
  axi_if.subord  req1,
  axi_if.manager mem
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  arb_state_t state, state_nxt;

  logic                  grant, last_grant;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] araddr_q, awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  logic       rd0, rd1, pend0, pend1, any_pend, sel, sel_rd;
  logic       gnt_rready, gnt_bready;
  logic       aw_hs, w_hs, wr_both_done;
  logic [1:0] ar_rdy, aw_rdy, w_rdy, r_vld, b_vld;
  logic       mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready;
  logic       r_fwd0, r_fwd1, b_fwd0, b_fwd1;
  logic       unused_prot;

  assign rd0      = req0.ARVALID;
  assign rd1      = req1.ARVALID;
  assign pend0    = rd0 | (req0.AWVALID & req0.WVALID);
  assign pend1    = rd1 | (req1.AWVALID & req1.WVALID);
  assign any_pend = pend0 | pend1;
  assign sel      = (pend0 & pend1) ? ~last_grant : pend1;
  // a requester offering both a read and a write is served the read first
  assign sel_rd   = sel ? rd1 : rd0;

  assign gnt_rready   = grant ? req1.RREADY : req0.RREADY;
  assign gnt_bready   = grant ? req1.BREADY : req0.BREADY;
  assign aw_hs        = mem_awvalid & mem.AWREADY;
  assign w_hs         = mem_wvalid & mem.WREADY;
  assign wr_both_done = (aw_done | aw_hs) & (w_done | w_hs);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:    if (any_pend) state_nxt = sel_rd ? ARB_RD_ADDR : ARB_WR_REQ;
      ARB_RD_ADDR: if (mem.ARREADY) state_nxt = ARB_RD_DATA;
      ARB_RD_DATA: if (mem.RVALID && gnt_rready) state_nxt = ARB_IDLE;
      ARB_WR_REQ:  if (wr_both_done) state_nxt = ARB_WR_RESP;
      ARB_WR_RESP: if (mem.BVALID && gnt_bready) state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    ar_rdy      = '0;
    aw_rdy      = '0;
    w_rdy       = '0;
    r_vld       = '0;
    b_vld       = '0;
    mem_arvalid = 1'b0;
    mem_awvalid = 1'b0;
    mem_wvalid  = 1'b0;
    mem_rready  = 1'b0;
    mem_bready  = 1'b0;
    if (!ARESET) begin
      case (state)
        ARB_IDLE: begin
          if (any_pend) begin
            if (sel_rd) begin
              ar_rdy[sel] = 1'b1;
            end else begin
              aw_rdy[sel] = 1'b1;
              w_rdy[sel]  = 1'b1;
            end
          end
        end
        ARB_RD_ADDR: mem_arvalid = 1'b1;
        ARB_RD_DATA: begin
          r_vld[grant] = mem.RVALID;
          mem_rready   = gnt_rready;
        end
        ARB_WR_REQ: begin
          mem_awvalid = ~aw_done;
          mem_wvalid  = ~w_done;
        end
        ARB_WR_RESP: begin
          b_vld[grant] = mem.BVALID;
          mem_bready   = gnt_bready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      grant      <= 1'b0;
      last_grant <= IDLE_LAST_GRANT;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      araddr_q   <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      if (state == ARB_IDLE && any_pend) begin
        grant      <= sel;
        last_grant <= sel;
        if (sel_rd) begin
          araddr_q <= sel ? req1.ARADDR : req0.ARADDR;
        end else begin
          awaddr_q <= sel ? req1.AWADDR : req0.AWADDR;
          wdata_q  <= sel ? req1.WDATA  : req0.WDATA;
          wstrb_q  <= sel ? req1.WSTRB  : req0.WSTRB;
        end
      end
      if (state == ARB_WR_REQ) begin
        if (wr_both_done) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
      end
    end
  end

  assign r_fwd0 = !ARESET && state == ARB_RD_DATA && !grant;
  assign r_fwd1 = !ARESET && state == ARB_RD_DATA &&  grant;
  assign b_fwd0 = !ARESET && state == ARB_WR_RESP && !grant;
  assign b_fwd1 = !ARESET && state == ARB_WR_RESP &&  grant;

  assign req0.ARREADY = ar_rdy[0];
  assign req0.AWREADY = aw_rdy[0];
  assign req0.WREADY  = w_rdy[0];
  assign req0.RVALID  = r_vld[0];
  assign req0.RDATA   = r_fwd0 ? mem.RDATA : '0;
  assign req0.RRESP   = r_fwd0 ? mem.RRESP : RESP_OK;
  assign req0.BVALID  = b_vld[0];
  assign req0.BRESP   = b_fwd0 ? mem.BRESP : RESP_OK;

  assign req1.ARREADY = ar_rdy[1];
  assign req1.AWREADY = aw_rdy[1];
  assign req1.WREADY  = w_rdy[1];
  assign req1.RVALID  = r_vld[1];
  assign req1.RDATA   = r_fwd1 ? mem.RDATA : '0;
  assign req1.RRESP   = r_fwd1 ? mem.RRESP : RESP_OK;
  assign req1.BVALID  = b_vld[1];
  assign req1.BRESP   = b_fwd1 ? mem.BRESP : RESP_OK;

  assign mem.ARADDR  = araddr_q;
  assign mem.ARPROT  = 3'b000;
  assign mem.ARVALID = mem_arvalid;
  assign mem.AWADDR  = awaddr_q;
  assign mem.AWPROT  = 3'b000;
  assign mem.AWVALID = mem_awvalid;
  assign mem.WDATA   = wdata_q;
  assign mem.WSTRB   = wstrb_q;
  assign mem.WVALID  = mem_wvalid;
  assign mem.RREADY  = mem_rready;
  assign mem.BREADY  = mem_bready;

  // requester protection bits are not forwarded; memory always sees 0
  assign unused_prot = ^{req0.ARPROT, req0.AWPROT, req1.ARPROT, req1.AWPROT};

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Directed bench for axil_mem_arbiter with a small AXI-Lite memory model.
module tb_axil_mem_arbiter;
  import axil_arb_pkg::*;

  logic ACLK;
  logic ARESET;
  logic mem_rst;
  logic ar_rdy_en, aw_rdy_en, w_rdy_en;

  int n_vec = 0;
  int n_err = 0;

  axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) r0 ();
  axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) r1 ();
  axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m ();

  axil_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .req0  (r0),
    .req1  (r1),
    .mem   (m)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // memory model: always-ready by default, R/B one cycle after acceptance
  logic [31:0] mem_arr [0:63];
  logic        aw_got, w_got, aw_have, w_have;
  logic [31:0] aw_addr_q, w_data_q, aw_a, w_d;
  logic [3:0]  w_strb_q, w_s;

  assign m.ARREADY = ar_rdy_en;
  assign m.AWREADY = aw_rdy_en;
  assign m.WREADY  = w_rdy_en;
  assign m.RRESP   = RESP_OK;
  assign m.BRESP   = RESP_OK;

  always_comb begin
    aw_have = aw_got | (m.AWVALID & m.AWREADY);
    aw_a    = aw_got ? aw_addr_q : m.AWADDR;
    w_have  = w_got | (m.WVALID & m.WREADY);
    w_d     = w_got ? w_data_q : m.WDATA;
    w_s     = w_got ? w_strb_q : m.WSTRB;
  end

  always_ff @(posedge ACLK or posedge mem_rst) begin
    if (mem_rst) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
      mem_arr[1] <= 32'h1111_1111;
      mem_arr[2] <= 32'h2222_2222;
      mem_arr[4] <= 32'hDEAD_BEEF;
      m.RVALID   <= 1'b0;
      m.RDATA    <= '0;
      m.BVALID   <= 1'b0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      if (m.ARVALID && m.ARREADY) begin
        m.RVALID <= 1'b1;
        m.RDATA  <= mem_arr[m.ARADDR[7:2]];
      end else if (m.RVALID && m.RREADY) begin
        m.RVALID <= 1'b0;
      end
      if (aw_have && w_have) begin
        for (int b = 0; b < 4; b++)
          if (w_s[b]) mem_arr[aw_a[7:2]][8*b +: 8] <= w_d[8*b +: 8];
        m.BVALID <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (m.AWVALID && m.AWREADY) begin
          aw_got    <= 1'b1;
          aw_addr_q <= m.AWADDR;
        end
        if (m.WVALID && m.WREADY) begin
          w_got    <= 1'b1;
          w_data_q <= m.WDATA;
          w_strb_q <= m.WSTRB;
        end
        if (m.BVALID && m.BREADY) m.BVALID <= 1'b0;
      end
    end
  end

  logic r1_active;
  assign r1_active = r1.ARREADY | r1.AWREADY | r1.WREADY | r1.RVALID | r1.BVALID
                   | (|r1.RDATA) | (|r1.RRESP) | (|r1.BRESP);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  initial begin
    ARESET = 1'b1;
    mem_rst = 1'b1;
    ar_rdy_en = 1'b1;
    aw_rdy_en = 1'b1;
    w_rdy_en  = 1'b1;
    r0.ARVALID = 0; r0.ARADDR = 0; r0.ARPROT = 0; r0.RREADY = 1;
    r0.AWVALID = 0; r0.AWADDR = 0; r0.AWPROT = 0; r0.BREADY = 1;
    r0.WVALID = 0; r0.WDATA = 0; r0.WSTRB = 0;
    r1.ARVALID = 0; r1.ARADDR = 0; r1.ARPROT = 0; r1.RREADY = 1;
    r1.AWVALID = 0; r1.AWADDR = 0; r1.AWPROT = 0; r1.BREADY = 1;
    r1.WVALID = 0; r1.WDATA = 0; r1.WSTRB = 0;

    // reset values
    #3;
    chk("rst_state", dut.state, ARB_IDLE);
    chk("rst_last_grant", dut.last_grant, 1);
    chk("rst_grant", dut.grant, 0);
    chk("rst_mem_valids", {m.ARVALID, m.AWVALID, m.WVALID, m.RREADY, m.BREADY}, 0);
    chk("rst_mem_addr_data", {m.ARADDR, m.AWADDR}, 0);
    chk("rst_mem_wdata", {m.WDATA, m.WSTRB}, 0);
    @(posedge ACLK);
    @(posedge ACLK);
    #2;
    ARESET = 1'b0;
    mem_rst = 1'b0;

    // simultaneous reads: req0 wins the first tie after reset
    tick();
    r0.ARVALID = 1; r0.ARADDR = 32'h4;
    r1.ARVALID = 1; r1.ARADDR = 32'h8;
    #1 chk("sim_c0_ar0", {r0.ARREADY, r1.ARREADY}, 2'b10);
    tick(); r0.ARVALID = 0;
    #1 chk("sim_c1_araddr", {m.ARVALID, m.ARADDR}, {1'b1, 32'h4});
    chk("sim_c1_ar1_wait", r1.ARREADY, 0);
    tick();
    #1 chk("sim_c2_r0", {r0.RVALID, r0.RDATA, r1.RVALID}, {1'b1, 32'h1111_1111, 1'b0});
    tick();
    #1 chk("sim_c3_ar1", {r0.ARREADY, r1.ARREADY}, 2'b01);
    tick(); r1.ARVALID = 0;
    #1 chk("sim_c4_araddr", m.ARADDR, 32'h8);
    tick();
    #1 chk("sim_c5_r1", {r1.RVALID, r1.RDATA, r0.RVALID}, {1'b1, 32'h2222_2222, 1'b0});

    // repeat: alternation serves req0 first again
    tick();
    r0.ARVALID = 1; r0.ARADDR = 32'h4;
    r1.ARVALID = 1; r1.ARADDR = 32'h8;
    #1 chk("alt_c0_ar0", {r0.ARREADY, r1.ARREADY}, 2'b10);
    tick(); r0.ARVALID = 0;
    tick();
    #1 chk("alt_c2_r0", r0.RDATA, 32'h1111_1111);
    tick();
    #1 chk("alt_c3_ar1", {r0.ARREADY, r1.ARREADY}, 2'b01);
    tick(); r1.ARVALID = 0;
    tick();
    #1 chk("alt_c5_r1", r1.RDATA, 32'h2222_2222);

    // single read by req0; req1 sees nothing at any point
    tick();
    r0.ARVALID = 1; r0.ARADDR = 32'h10;
    #1 chk("one_c0", {r0.ARREADY, r1_active}, 2'b10);
    tick(); r0.ARVALID = 0;
    #1 chk("one_c1", {m.ARVALID, m.ARADDR, r1_active}, {1'b1, 32'h10, 1'b0});
    tick();
    #1 chk("one_c2", {r0.RVALID, r0.RDATA, m.RREADY, r1_active}, {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0});
    tick();
    #1 chk("one_c3", {dut.state, r0.RVALID, r1_active}, {ARB_IDLE, 1'b0, 1'b0});

    // write by req1, then read back by req0
    r1.AWVALID = 1; r1.AWADDR = 32'h20;
    r1.WVALID = 1; r1.WDATA = 32'h1234_5678; r1.WSTRB = 4'hF;
    #1 chk("wr_c0_rdy", {r1.AWREADY, r1.WREADY, r0.AWREADY, r0.WREADY}, 4'b1100);
    tick(); r1.AWVALID = 0; r1.WVALID = 0;
    #1 chk("wr_c1_mem", {m.AWVALID, m.WVALID, m.AWADDR, m.WDATA, m.WSTRB},
           {1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'hF});
    tick();
    #1 chk("wr_c2_b", {r1.BVALID, r1.BRESP, r0.BVALID, m.BREADY}, {1'b1, 2'b00, 1'b0, 1'b1});
    tick();
    r0.ARVALID = 1; r0.ARADDR = 32'h20;
    #1 chk("wrd_c0", r0.ARREADY, 1);
    tick(); r0.ARVALID = 0;
    tick();
    #1 chk("wrd_c2", {r0.RVALID, r0.RDATA}, {1'b1, 32'h1234_5678});

    // back-pressure on R from req0 while req1 waits
    tick();
    r0.ARVALID = 1; r0.ARADDR = 32'h10; r0.RREADY = 0;
    #1 chk("bp_c0", r0.ARREADY, 1);
    tick(); r0.ARVALID = 0;
    r1.ARVALID = 1; r1.ARADDR = 32'h8;
    #1 chk("bp_c1_ar1", r1.ARREADY, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1 chk("bp_hold", {r0.RVALID, r0.RDATA, m.RREADY, r1.ARREADY, dut.state},
             {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, ARB_RD_DATA});
    end
    tick(); r0.RREADY = 1;
    #1 chk("bp_release", {m.RREADY, r0.RVALID, r1.ARREADY}, 3'b110);
    tick();
    #1 chk("bp_ar1_after", {r1.ARREADY, r0.ARREADY}, 2'b10);
    tick(); r1.ARVALID = 0;
    tick();
    #1 chk("bp_r1_data", {r1.RVALID, r1.RDATA}, {1'b1, 32'h2222_2222});

    // split write handshake: AWREADY at cycle 1, WREADY at cycle 3
    tick();
    w_rdy_en = 0;
    r0.AWVALID = 1; r0.AWADDR = 32'h30;
    r0.WVALID = 1; r0.WDATA = 32'hA5A5_5A5A; r0.WSTRB = 4'hF;
    #1 chk("spl_c0", {r0.AWREADY, r0.WREADY}, 2'b11);
    tick(); r0.AWVALID = 0; r0.WVALID = 0;
    #1 chk("spl_c1", {m.AWVALID, m.WVALID}, 2'b11);
    tick();
    #1 chk("spl_c2", {m.AWVALID, m.WVALID, dut.state}, {1'b0, 1'b1, ARB_WR_REQ});
    tick(); w_rdy_en = 1;
    #1 chk("spl_c3", {m.AWVALID, m.WVALID, m.WDATA}, {1'b0, 1'b1, 32'hA5A5_5A5A});
    tick();
    #1 chk("spl_c4", {dut.state, r0.BVALID, m.WVALID}, {ARB_WR_RESP, 1'b1, 1'b0});

    // reset pulse while in ARB_RD_DATA
    tick();
    r0.ARVALID = 1; r0.ARADDR = 32'h4;
    tick(); r0.ARVALID = 0;
    tick();
    #1 chk("rr_pre", {r0.RVALID, dut.state}, {1'b1, ARB_RD_DATA});
    ARESET = 1'b1;
    #1 chk("rr_async", {r0.RVALID, r0.RDATA, m.RREADY, m.ARVALID}, 0);
    chk("rr_state", {dut.state, dut.grant, dut.last_grant}, {ARB_IDLE, 1'b0, 1'b1});
    tick(); ARESET = 1'b0;
    #1 chk("rr_no_resp", {r0.RVALID, r1.RVALID}, 2'b00);
    tick();
    r1.ARVALID = 1; r1.ARADDR = 32'h8;
    #1 chk("rr_ar1", {r1.ARREADY, r0.ARREADY}, 2'b10);
    tick(); r1.ARVALID = 0;
    #1 chk("rr_c1", {m.ARVALID, m.ARADDR}, {1'b1, 32'h8});
    tick();
    #1 chk("rr_c2", {r1.RVALID, r1.RDATA, r0.RVALID}, {1'b1, 32'h2222_2222, 1'b0});

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
